// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: CPU read port of the UART receive FIFO
interface uart_rx_fifo_if;
  logic        i_request;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_not_empty;
  modport master (output i_request, input o_rdata, o_ready, o_not_empty);
  modport slave  (input i_request, output o_rdata, o_ready, o_not_empty);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 receiver feeding a read FIFO with sticky error flags
module uart_rx_fifo #(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  uart_rx_fifo_if.slave bus,
  input  logic          UART_RX
);
  localparam int DIV_RAW = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int TW = $clog2(DIV + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t        state_q;
  logic [3:0]    s_q;
  logic [2:0]    b_q;
  logic [7:0]    shift_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [31:0]   rdata_q, rdata_d;
  logic          busy_q, busy_d, fe_q, fe_d, ov_q, ov_d;
  logic          tick, leave_idle, push, fe_set, empty, full, rd_start, pop, wr;
  // Tick generation, stop-bit verdicts, FIFO pointers and the read handshake
  always_comb begin
    rx_meta_d = UART_RX;
    rx_s_d = rx_meta_q;
    tick = tick_cnt_q == TW'(DIV - 1);
    leave_idle = state_q == IDLE && !rx_s_q;
    tick_cnt_d = (leave_idle || tick) ? '0 : tick_cnt_q + TW'(1);
    push = state_q == STOP && tick && s_q == 4'd15 && rx_s_q;
    fe_set = state_q == STOP && tick && s_q == 4'd15 && !rx_s_q;
    empty = wp_q == rp_q;
    full = wp_q[AW] != rp_q[AW] && wp_q[AW-1:0] == rp_q[AW-1:0];
    rd_start = bus.i_request && !busy_q;
    pop = rd_start && !empty;
    wr = push && (!full || pop);
    wp_d = wp_q + PW'(wr);
    rp_d = rp_q + PW'(pop);
    busy_d = bus.i_request;
    fe_d = fe_set || (fe_q && !rd_start);
    ov_d = (push && !wr) || (ov_q && !rd_start);
    rdata_d = rd_start ? {21'b0, fe_q, ov_q, !empty, empty ? 8'h00 : mem_q[rp_q[AW-1:0]]} : rdata_q;
  end
  // Deframing FSM: counts oversample ticks and samples each bit at its midpoint
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      state_q <= IDLE;
      s_q <= '0;
      b_q <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (!rx_s_q) begin
          state_q <= START;
          s_q <= '0;
        end
        START: if (tick) begin
          s_q <= s_q + 4'd1;
          if (s_q == 4'd7) begin
            s_q <= '0;
            b_q <= '0;
            state_q <= rx_s_q ? IDLE : DATA;
          end
        end
        DATA: if (tick) begin
          s_q <= s_q + 4'd1;
          if (s_q == 4'd15) begin
            shift_q[b_q] <= rx_s_q;
            b_q <= b_q + 3'd1;
            if (b_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: if (tick) begin
          s_q <= s_q + 4'd1;
          if (s_q == 4'd15) state_q <= rx_s_q ? IDLE : BREAK;
        end
        BREAK: if (rx_s_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  // State registers for synchronizer, tick counter, FIFO pointers and read port
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      tick_cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      rdata_q <= '0;
      busy_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q <= rx_s_d;
      tick_cnt_q <= tick_cnt_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      rdata_q <= rdata_d;
      busy_q <= busy_d;
      fe_q <= fe_d;
      ov_q <= ov_d;
    end
  // Byte storage, written only on accepted pushes
  always_ff @(posedge i_clock)
    if (wr) mem_q[wp_q[AW-1:0]] <= shift_q;
  assign bus.o_rdata = rdata_q;
  assign bus.o_ready = busy_q && bus.i_request;
  assign bus.o_not_empty = !empty;
endmodule
